// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH multiplier. It uses one adder and a
//   2:1 operand select, and performs one partial product per clock.
//   A multiply accepted on a start edge finishes WIDTH edges later.
//   done then pulses for one cycle.
//   The product is held until the next accepted start.
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high reset
//   start   : multiply request, sampled in IDLE and DONE
//   a       : multiplicand (unsigned, WIDTH bits)
//   b       : multiplier   (unsigned, WIDTH bits)
//   product : accumulator/shift register. It is a*b while done=1 and until
//             the next start. It shows partial values while busy=1.
//   busy    : a multiplication is in progress
//   done    : one-cycle pulse, product just became valid
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   partial;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // The low half of P starts as the multiplier. Its LSB selects the addend.
  // The sum is kept WIDTH+1 bits wide so the carry lands in the top bit
  // after the right shift.
  always_comb begin
    partial = p_q[0] ? a_q : '0;
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, partial};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a start exactly like IDLE, so back-to-back
        // operations need no idle gap.
        if (start) begin
          a_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        p_d   = {sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product = p_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int n_chk  = 0;
  int n_fail = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse for one edge. Afterwards we sit 1 time unit past
  // the accepting edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  // Wait (bounded) for done and count edges since the accepting edge.
  // The wait begins with 'lat0' edges already elapsed.
  task automatic wait_done(input string tag, input int unsigned exp, input int lat0);
    int  lat;
    bit  busy_ok;
    lat = lat0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), W);
    chk({tag, "_busy_held"}, 32'(busy_ok), 1);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_product"}, 32'(product), exp);
  endtask

  initial begin
    int unsigned ra, rb;
    bit stray;

    // Reset state
    #1;
    chk("rst_product", 32'(product), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Basic op, done pulse width, hold
    launch(8'h0D, 8'h0B);
    wait_done("basic", 8'h0D * 8'h0B, 0);
    @(posedge clk); #1;
    chk("basic_done_pulse", 32'(done), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("basic_hold", 32'(product), 32'h008F);

    // Boundary operands
    launch(8'hFF, 8'hFF); wait_done("max", 32'hFE01, 0);
    launch(8'h00, 8'h5A); wait_done("a_zero", 0, 0);
    launch(8'hA5, 8'h00); wait_done("b_zero", 0, 0);
    launch(8'h01, 8'h80); wait_done("one_msb", 32'h0080, 0);

    // Start during RUN is ignored
    launch(8'h12, 8'h34);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign_start", 32'h03A8, 3);

    // Back-to-back: restart during the DONE cycle
    launch(8'h10, 8'h10);
    wait_done("b2b_first", 32'h0100, 0);
    chk("b2b_done_seen", 32'(done), 1);
    launch(8'h03, 8'h07);
    wait_done("b2b_second", 32'h0015, 0);

    // Asynchronous reset mid-run
    launch(8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_product", 32'(product), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk); reset = 1'b0;
    stray = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) stray = 1'b1;
    end
    chk("arst_no_stray_done", 32'(stray), 0);
    launch(8'h02, 8'h03); wait_done("arst_recover", 32'h0006, 0);

    // Random operands against plain multiplication
    for (int i = 0; i < 12; i++) begin
      ra = $urandom_range(255);
      rb = $urandom_range(255);
      launch(W'(ra), W'(rb));
      wait_done($sformatf("rand%0d", i), ra * rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
